div_seq: RTL and testbench

- Request-side sequencer for the iterative 32-bit divide core.
- Accepts RISC-V M-extension divide ops (DIV/DIVU/REM/REMU) from the execute stage over a valid/ready handshake.
- Resolves divide-by-zero and signed overflow itself, and kicks the divide core for all other ops.
- Corrects the remainder sign and returns one tagged result to writeback.

---
 rtl/div_seq.sv | 132 +++++++++++++
 tb/tb_div_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Request-side sequencer for the iterative 32-bit divide core: resolves divide-by-zero and
// signed overflow locally, otherwise drives the core and sign-corrects the remainder.
// Optional DIV_REUSE_EN adds a one-entry result cache that bypasses the core on repeated operands.
module div_seq #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             div_kick,
  output logic             div_unsigned,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divider,
  input  logic             div_ready,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder
);

  typedef enum logic [1:0] {IDLE, KICK, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [31:0]      rs1_reg, rs2_reg, data_reg;
  logic [TAG_W-1:0] tag_reg;

  logic        accept;
  logic        fast_zero, fast_ovf, fast_path;
  logic [31:0] fast_data;
  logic [31:0] rem_mag, rem_fix, core_result;
  logic        cache_hit;
  logic [31:0] cache_data;

  assign accept    = req_valid && req_ready;
  assign fast_zero = (req_rs2 == 32'd0);
  assign fast_ovf  = !req_op[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
  assign fast_path = fast_zero || fast_ovf;
  assign fast_data = fast_zero ? (req_op[1] ? req_rs1 : 32'hFFFF_FFFF)
                               : (req_op[1] ? 32'd0   : 32'h8000_0000);

  // The core's remainder follows the quotient sign; the result must follow the dividend.
  assign rem_mag     = (rs1_reg[31] ^ rs2_reg[31]) ? -div_remainder : div_remainder;
  assign rem_fix     = op_reg[0] ? div_remainder : (rs1_reg[31] ? -rem_mag : rem_mag);
  assign core_result = op_reg[1] ? rem_fix : div_quotient;

`ifdef DIV_REUSE_EN
  logic        cache_valid_reg, cache_uns_reg;
  logic [31:0] cache_rs1_reg, cache_rs2_reg, cache_quot_reg, cache_rem_reg;

  assign cache_hit  = cache_valid_reg && !fast_path && (cache_rs1_reg == req_rs1) &&
                      (cache_rs2_reg == req_rs2) && (cache_uns_reg == req_op[0]);
  assign cache_data = req_op[1] ? cache_rem_reg : cache_quot_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_reg <= 1'b0;
      cache_uns_reg   <= 1'b0;
      cache_rs1_reg   <= '0;
      cache_rs2_reg   <= '0;
      cache_quot_reg  <= '0;
      cache_rem_reg   <= '0;
    end else if (state_reg == WAIT && div_ready) begin
      cache_valid_reg <= 1'b1;
      cache_uns_reg   <= op_reg[0];
      cache_rs1_reg   <= rs1_reg;
      cache_rs2_reg   <= rs2_reg;
      cache_quot_reg  <= div_quotient;
      cache_rem_reg   <= rem_fix;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (fast_path || cache_hit) ? RESP : KICK;
      KICK: if (div_ready) state_next = WAIT;
      WAIT: if (div_ready) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    div_kick  = (state_reg == KICK);
    rsp_valid = (state_reg == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg   <= '0;
      rs1_reg  <= '0;
      rs2_reg  <= '0;
      tag_reg  <= '0;
      data_reg <= '0;
    end else if (accept) begin
      op_reg   <= req_op;
      rs1_reg  <= req_rs1;
      rs2_reg  <= req_rs2;
      tag_reg  <= req_tag;
      data_reg <= fast_path ? fast_data : cache_data;
    end else if (state_reg == WAIT && div_ready) begin
      data_reg <= core_result;
    end
  end

  assign rsp_data     = data_reg;
  assign rsp_tag      = tag_reg;
  assign div_unsigned = op_reg[0];
  assign div_dividend = rs1_reg;
  assign div_divider  = rs2_reg;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: behavioural divide core plus a scoreboard of expected responses,
// checking data, tag, latency and kick count per transaction.
module tb_div_seq;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_REUSE_EN
  localparam int HIT_LAT = 1, HIT_KICKS = 0;
`else
  localparam int HIT_LAT = 35, HIT_KICKS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0;
  logic [4:0]  req_tag = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        busy, div_kick, div_unsigned, div_ready;
  logic [31:0] div_dividend, div_divider, div_quotient, div_remainder;

  int n_cmp = 0, n_err = 0, cyc = 0;

  typedef struct {logic [31:0] data; logic [4:0] tag;} exp_t;
  exp_t sb_q[$];

  div_seq #(.TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy), .div_kick(div_kick), .div_unsigned(div_unsigned),
    .div_dividend(div_dividend), .div_divider(div_divider), .div_ready(div_ready),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: 32 busy cycles after a kick, remainder signed like the quotient.
  int core_cnt = 0;
  logic [31:0] core_q = '0, core_r = '0;
  assign div_ready     = (core_cnt == 0);
  assign div_quotient  = core_q;
  assign div_remainder = core_r;

  function automatic logic [31:0] absv(logic [31:0] v, logic uns);
    return (!uns && v[31]) ? -v : v;
  endfunction

  function automatic logic [31:0] core_div(logic [31:0] a, logic [31:0] b, logic uns, logic want_rem);
    logic [31:0] m;
    m = want_rem ? (absv(a, uns) % absv(b, uns)) : (absv(a, uns) / absv(b, uns));
    return (!uns && (a[31] ^ b[31])) ? -m : m;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      core_cnt <= 0;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end else if (div_kick) begin
      core_cnt <= 32;
      core_q   <= core_div(div_dividend, div_divider, div_unsigned, 1'b0);
      core_r   <= core_div(div_dividend, div_divider, div_unsigned, 1'b1);
    end
  end

  function automatic logic [31:0] ref_div(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag,
                      int exp_lat, int exp_kicks, int hold);
    int acc, kicks, waited, lat;
    exp_t e;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    sb_q.push_back('{data: ref_div(op, a, b), tag: tag});
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_rs1 = $urandom; req_rs2 = $urandom; req_tag = 5'($urandom);
    kicks = 0;
    waited = 0;
    while (!rsp_valid && waited < 200) begin
      kicks += int'(div_kick);
      @(negedge clk);
      waited++;
    end
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
    lat = cyc - acc;
    check("latency", 32'(lat), 32'(exp_lat));
    check("kick_count", 32'(kicks), 32'(exp_kicks));
    e = sb_q.pop_front();
    check("rsp_data", rsp_data, e.data);
    check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
    $display("txn op=%0d a=%h b=%h tag=%0d -> data=%h tag=%0d lat=%0d kicks=%0d",
             op, a, b, tag, rsp_data, rsp_tag, lat, kicks);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_data", rsp_data, e.data);
      check("hold_tag", 32'(rsp_tag), 32'(e.tag));
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("no_dup_rsp", 32'(rsp_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_div_kick", 32'(div_kick), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divider", div_divider, 32'd0);
    reset = 1'b0;

    send(OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd1,  35, 1, 0);
    send(OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd2,  HIT_LAT, HIT_KICKS, 0);
    send(OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd3,  35, 1, 0);
    send(OP_DIVU, 32'hFFFF_FFFF, 32'd2,         5'd4,  35, 1, 0);
    send(OP_REMU, 32'hFFFF_FFFF, 32'd2,         5'd5,  HIT_LAT, HIT_KICKS, 0);
    send(OP_DIV,  32'h1234,      32'd0,         5'd6,  1, 0, 0);
    send(OP_REMU, 32'h1234,      32'd0,         5'd7,  1, 0, 0);
    send(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  1, 0, 0);
    send(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  1, 0, 0);
    send(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 35, 1, 0);
    send(OP_DIVU, 32'd100,       32'd9,         5'd11, 35, 1, 10);

    // Abort a division mid-flight; no response may ever appear for it.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_tag = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_no_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(rsp_valid);
    end
    check("abort_no_rsp", 32'(seen), 32'd0);

    send(OP_DIV, 32'd100, 32'd7, 5'd12, 35, 1, 0);
    send(OP_REM, 32'd100, 32'd7, 5'd13, HIT_LAT, HIT_KICKS, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
